// File: rtl/fp_pkg.sv
// Shared types and constants for the FP issue controller: opcodes, FSM states,
// the quiet-NaN result returned on a unit timeout, and the cycle-count width.
package fp_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    AS_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DIV_START,
    DIV_ARM,
    DIV_WAIT,
    RESP
  } state_t;

  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam int unsigned CYC_W = 6;

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// FP issue controller (slave).
interface fp_issue_ctrl_if;
  import fp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  opcode_t           req_op;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  opcode_t           rsp_op;
  logic [CYC_W-1:0]  rsp_cycles;
  logic              rsp_timeout;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_op, rsp_cycles, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_op, rsp_cycles, rsp_timeout
  );

endinterface

// File: rtl/fp_issue_ctrl_sat_counter.sv
// Saturating up-counter; exposes the value it will hold after this edge so the
// caller can act on the count including the current cycle.
module sat_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count_d
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] base;

  // clr and inc together restart the count with the current cycle included
  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != '1)) count_d = base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding issue controller dispatching one FP operation at a time to
// the add/sub, multiply or divide unit and returning its result in order.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  fp_issue_ctrl_if.slave bus,
  output logic        as_opcode,
  output logic [31:0] as_a,
  output logic [31:0] as_b,
  input  logic [31:0] as_result,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_stb,
  input  logic        mul_ack,
  input  logic [31:0] mul_result,
  input  logic        mul_result_stb,
  output logic        mul_result_ack,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [31:0] div_result
);

  localparam logic [CYC_W-1:0] TO_LIM = CYC_W'(TIMEOUT);

  state_t           state_q, state_d;
  opcode_t          op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic             to_q, to_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] cnt_d;
  logic             ready, accept, timeout_hit;

  assign ready  = (state_q == IDLE) && !rst;
  assign accept = bus.req_valid && ready;

  sat_counter #(.WIDTH(CYC_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (accept || (state_q != IDLE)),
    .count_d (cnt_d)
  );

  // cnt_d counts the accept cycle as cycle 0, so it equals the cycle index of RESP
  assign timeout_hit = (cnt_d >= TO_LIM);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    to_d           = to_q;
    cyc_d          = cyc_q;
    mul_stb        = 1'b0;
    mul_result_ack = 1'b0;
    div_start      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = bus.req_op;
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          to_d = 1'b0;
          unique case (bus.req_op)
            ADD, SUB: state_d = AS_WAIT;
            MUL:      state_d = MUL_REQ;
            DIV:      state_d = DIV_START;
            default:  state_d = IDLE;
          endcase
        end
      end
      AS_WAIT: begin
        res_d   = as_result;
        cyc_d   = cnt_d;
        state_d = RESP;
      end
      MUL_REQ: begin
        mul_stb = 1'b1;
        if (mul_ack) begin
          state_d = MUL_WAIT;
        end else if (timeout_hit) begin
          res_d = QNAN; to_d = 1'b1; cyc_d = cnt_d; state_d = RESP;
        end
      end
      MUL_WAIT: begin
        if (mul_result_stb) begin
          mul_result_ack = 1'b1;
          res_d = mul_result; cyc_d = cnt_d; state_d = RESP;
        end else if (timeout_hit) begin
          res_d = QNAN; to_d = 1'b1; cyc_d = cnt_d; state_d = RESP;
        end
      end
      DIV_START: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = DIV_ARM;
        end else if (timeout_hit) begin
          res_d = QNAN; to_d = 1'b1; cyc_d = cnt_d; state_d = RESP;
        end
      end
      DIV_ARM: state_d = DIV_WAIT;
      DIV_WAIT: begin
        if (!div_busy) begin
          res_d = div_result; cyc_d = cnt_d; state_d = RESP;
        end else if (timeout_hit) begin
          res_d = QNAN; to_d = 1'b1; cyc_d = cnt_d; state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // reset takes precedence over any unit handshake in flight
    if (rst) begin
      mul_stb        = 1'b0;
      mul_result_ack = 1'b0;
      div_start      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = (state_q == RESP) && !rst;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_op      = op_q;
  assign bus.rsp_cycles  = cyc_q;
  assign bus.rsp_timeout = to_q;

  assign as_opcode = (op_q == SUB);
  assign as_a      = a_q;
  assign as_b      = b_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign div_a     = a_q;
  assign div_b     = b_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: expected responses are queued when a
// request is driven and compared when the controller presents them.
module tb_fp_issue_ctrl;
  import fp_pkg::*;

  typedef struct {
    opcode_t     op;
    logic [31:0] res;
    logic [5:0]  cyc;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_opcode;
  logic [31:0] as_a, as_b, as_result;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        mul_stb, mul_ack, mul_result_stb, mul_result_ack;
  logic [31:0] div_a, div_b, div_result;
  logic        div_start, div_busy;

  fp_issue_ctrl_if bus();

  fp_issue_ctrl #(.TIMEOUT(63)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .as_opcode      (as_opcode),
    .as_a           (as_a),
    .as_b           (as_b),
    .as_result      (as_result),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_stb        (mul_stb),
    .mul_ack        (mul_ack),
    .mul_result     (mul_result),
    .mul_result_stb (mul_result_stb),
    .mul_result_ack (mul_result_ack),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_start      (div_start),
    .div_busy       (div_busy),
    .div_result     (div_result)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  int          acc_cyc, xfer_cyc, rsp_done;
  int          ack_cnt, ack_cyc, start_cnt, start_cyc;
  logic        start_busy, rsp_seen;
  logic [31:0] st_a, st_b, ml_a, ml_b;

  task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Add/sub unit stand-in: answers only the operand pairs the bench issues
  function automatic logic [31:0] as_model(logic sub, logic [31:0] a, logic [31:0] b);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000)  return 32'h4000_0000;
    return 32'hDEAD_BEEF;
  endfunction

  assign as_result = as_model(as_opcode, as_a, as_b);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      rsp_seen = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (mul_result_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (mul_stb) begin ml_a = mul_a; ml_b = mul_b; end
      if (div_start) begin
        start_cnt++; start_cyc = cyc; start_busy = div_busy; st_a = div_a; st_b = div_b;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_rsp", bus.rsp_valid, 1'b0);
        end else begin
          if (!rsp_seen) check_eq("latency", cyc - acc_cyc, sb[0].cyc);
          rsp_seen = 1'b1;
          check_eq("rsp_result", bus.rsp_result, sb[0].res);
          check_eq("rsp_op", bus.rsp_op, sb[0].op);
          check_eq("rsp_cycles", bus.rsp_cycles, sb[0].cyc);
          check_eq("rsp_timeout", bus.rsp_timeout, sb[0].to);
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            rsp_seen = 1'b0;
            xfer_cyc = cyc;
            rsp_done++;
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(opcode_t op, logic [31:0] a, logic [31:0] b,
                      logic [31:0] res, logic [5:0] c, logic to);
    logic got;
    sb.push_back('{op: op, res: res, cyc: c, to: to});
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
      next_cycle();
    end
    bus.req_valid = 1'b0;
    if (!got) check_eq("accept_wait", got, 1'b1);
  endtask

  task automatic wait_done(int target);
    for (int i = 0; i < 200 && rsp_done < target; i++) next_cycle();
    if (rsp_done < target) check_eq("rsp_wait", rsp_done, target);
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    check_eq({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check_eq({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check_eq({tag, "_rsp_result"}, bus.rsp_result, 32'h0);
    check_eq({tag, "_rsp_cycles"}, bus.rsp_cycles, 6'd0);
    check_eq({tag, "_mul_stb"}, mul_stb, 1'b0);
    check_eq({tag, "_mul_result_ack"}, mul_result_ack, 1'b0);
    check_eq({tag, "_div_start"}, div_start, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = ADD; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    mul_ack = 1'b0; mul_result = '0; mul_result_stb = 1'b0;
    div_busy = 1'b0; div_result = '0;
    acc_cyc = 0; xfer_cyc = 0; rsp_done = 0; ack_cnt = 0; ack_cyc = 0;
    start_cnt = 0; start_cyc = 0; start_busy = 1'b0; rsp_seen = 1'b0;
    st_a = '0; st_b = '0; ml_a = '0; ml_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // stray multiplier result while idle must be ignored
    next_cycle();
    mul_result_stb = 1'b1; mul_result = 32'h0BAD_0BAD;
    next_cycle();
    mul_result_stb = 1'b0;

    send(ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6'd2, 1'b0);
    wait_done(1);
    check_eq("idle_stray_ack", ack_cnt, 0);

    // MUL: ack two cycles late, result strobe four cycles after ack
    send(MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6'd8, 1'b0);
    next_cycle();
    mul_result_stb = 1'b1; mul_result = 32'h0BAD_F00D;
    next_cycle();
    mul_result_stb = 1'b0; mul_ack = 1'b1;
    next_cycle();
    mul_ack = 1'b0;
    repeat (3) next_cycle();
    mul_result_stb = 1'b1; mul_result = 32'h40C0_0000;
    next_cycle();
    mul_result_stb = 1'b0;
    wait_done(2);
    check_eq("mul_ack_pulses", ack_cnt, 1);
    check_eq("mul_ack_cycle", ack_cyc - acc_cyc, 7);
    check_eq("mul_a", ml_a, 32'h4000_0000);
    check_eq("mul_b", ml_b, 32'h4040_0000);

    // DIV: busy high for three cycles from accept
    div_busy = 1'b1;
    send(DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 6'd8, 1'b0);
    next_cycle();
    next_cycle();
    div_busy = 1'b0; div_result = 32'h4040_0000;
    next_cycle();
    div_busy = 1'b1;
    repeat (3) next_cycle();
    div_busy = 1'b0;
    wait_done(3);
    check_eq("div_start_pulses", start_cnt, 1);
    check_eq("div_start_cycle", start_cyc - acc_cyc, 3);
    check_eq("div_start_busy", start_busy, 1'b0);
    check_eq("div_a", st_a, 32'h40C0_0000);
    check_eq("div_b", st_b, 32'h4000_0000);

    // MUL with no ack ever: abort with qNaN at the timeout cycle
    send(MUL, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 6'd63, 1'b1);
    wait_done(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mul_stb_after_to", mul_stb, 1'b0);
      next_cycle();
    end
    check_eq("to_ack_pulses", ack_cnt, 1);

    // Response stall with a SUB waiting behind it
    bus.rsp_ready = 1'b0;
    send(ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6'd2, 1'b0);
    sb.push_back('{op: SUB, res: 32'h4000_0000, cyc: 6'd2, to: 1'b0});
    bus.req_valid = 1'b1; bus.req_op = SUB;
    bus.req_a = 32'h4040_0000; bus.req_b = 32'h3F80_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("stall_req_ready", bus.req_ready, 1'b0);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
      next_cycle();
    end
    bus.req_valid = 1'b0;
    check_eq("sub_accepted", got, 1'b1);
    check_eq("sub_after_xfer", acc_cyc - xfer_cyc, 1);
    wait_done(6);

    // Reset while waiting on the divider abandons the operation
    div_busy = 1'b0;
    send(DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 6'd8, 1'b0);
    div_busy = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    void'(sb.pop_back());
    next_cycle();
    rst = 1'b0;
    check_reset_outputs("midrst");
    next_cycle();
    div_busy = 1'b0;
    repeat (5) next_cycle();
    check_eq("midrst_no_rsp", rsp_done, 6);

    send(SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 6'd2, 1'b0);
    wait_done(7);
    check_eq("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
